mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer that shares the CPU's single unified memory between the instruction-fetch side (I) and the data side (D, loads and stores). The memory has a fixed access latency. The arbiter accepts one request at a time, drives the memory for the required cycles, captures read data and returns a one-cycle completion pulse to the requester. It sits between the fetch/memory stages of the 16-bit CPU and the memory model.

## Interface
- LATENCY, 4: cycles from the memory issue cycle to valid mem_rdata; legal range 1..15.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_req  in  1  fetch request (level); held with i_addr until i_valid.
- i_addr  in  16  fetch address.
- i_rdata  out  16  fetched word; registered.
- i_valid  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request (level); held with d_wr, d_addr, d_wdata until d_valid.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  16  data address.
- d_wdata  in  16  store data.
- d_rdata  out  16  load data; registered; unchanged by stores.
- d_valid  out  1  one-cycle completion pulse for loads and stores.
- mem_en  out  1  memory access strobe; high only in the issue cycle.
- mem_wr  out  1  write enable; qualified by mem_en.
- mem_addr  out  16  memory address; held from issue through the end of WAIT.
- mem_wdata  out  16  store data; held like mem_addr.
- mem_rdata  in  16  read data; valid LATENCY cycles after the issue cycle.

## Operation
- FSM states:
  - IDLE: samples requests. If any request is pending, it latches the winner's attributes and the owner bit, then moves to ISSUE. Otherwise it stays in IDLE.
  - ISSUE: mem_en=1. Loads a down-counter with LATENCY. Moves to WAIT.
  - WAIT: decrements the counter each cycle. On the last WAIT cycle (counter = 1), mem_rdata is captured into the owner's rdata register on a load; nothing is captured on a store. Moves to RESP.
  - RESP: asserts the owner's valid pulse. Always moves to IDLE.
- Arbitration:
  - Only one access is outstanding at a time.
  - Requests are sampled only in IDLE. Requests changing in other states are ignored.
  - I requests are always reads. d_wr drives mem_wr.
  - Default policy: D has priority when both requests are pending.
- Registered outputs: mem_en, mem_wr, mem_addr, mem_wdata, rdata and valid are all registered, with no combinational input-to-output path.
- Reset:
  - Reset forces IDLE and clears the counter, the owner bit and the starvation counter.
  - Reset value of every output is 0.
  - An access in flight when reset asserts is dropped: no valid pulse is generated.
- Edge cases:
  - The requester sees valid in cycle X. It must present its next request, or drop req, from cycle X+1, which is an IDLE cycle. This allows back-to-back accesses.
  - A request raised during ISSUE, WAIT or RESP waits for the next IDLE.
  - LATENCY=1 gives a single WAIT cycle.

## Timing
- With d_req (or i_req) high in IDLE cycle S:
  - mem_en is high in S+1.
  - WAIT covers S+2 .. S+1+LATENCY.
  - mem_rdata is sampled at the end of cycle S+1+LATENCY.
  - valid is high in S+2+LATENCY.
  - IDLE resumes in S+3+LATENCY.
- Occupancy is LATENCY+3 cycles per access. With LATENCY=4 that is 7 cycles.
- Stores have the same timing as loads.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A 2-bit counter increments on each D grant made while i_req is also pending.
  - When the counter equals 2 and both requests are pending, I is granted and the counter clears.
  - Any I grant clears the counter.
- Not defined:
  - Strict D priority; I can starve indefinitely.
  - The counter logic is absent.

## Test plan
- LATENCY=4, i_req=1, i_addr=0x0010, memory returns 0xA5A5 → mem_en in cycle 1 with mem_addr=0x0010 and mem_wr=0; i_valid in cycle 6 with i_rdata=0xA5A5; state IDLE in cycle 7.
- d_req with d_wr=1, d_addr=0x0200, d_wdata=0x1234, and d_rdata pre-loaded with 0xBEEF → mem_en=1 and mem_wr=1 for exactly one cycle, mem_wdata=0x1234 held through WAIT; d_valid pulses once; d_rdata stays 0xBEEF.
- i_req and d_req raised in the same IDLE cycle → D is served first; I's mem_en comes 7 cycles after D's mem_en; i_valid comes 7 cycles after d_valid.
- Both requesters re-request immediately after each completion for 6 accesses → grant order is D,D,I,D,D,I with MEM_ARB_STARVE_GUARD_EN, and D,D,D,D,D,D without it.
- rst_n=0 for one cycle during the second WAIT cycle of a load → all outputs read 0 the next cycle; no d_valid is ever produced for that load; a new request then completes normally with the standard latency.
- Back-to-back D loads to 0x0000 then 0x0001, with the second request presented in the cycle after the first d_valid → second mem_en 2 cycles after the first d_valid; no duplicate issue of 0x0000.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter and sequencer for a single fixed-latency unified memory.
// Optional I-side starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       is_store;
  logic       grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [1:0] starve;

  // After two D grants that bypassed a waiting I request, the next contended grant goes to I.
  always_comb begin
    grant_d = d_req && !(i_req && (starve == 2'd2));
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner     <= 1'b0;
      is_store  <= 1'b0;
      i_rdata   <= 16'h0000;
      i_valid   <= 1'b0;
      d_rdata   <= 16'h0000;
      d_valid   <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve    <= 2'd0;
`endif
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner     <= grant_d;
            is_store  <= grant_d && d_wr;
            mem_en    <= 1'b1;
            mem_wr    <= grant_d && d_wr;
            mem_addr  <= grant_d ? d_addr : i_addr;
            mem_wdata <= grant_d ? d_wdata : 16'h0000;
            state     <= ISSUE;
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (!grant_d) begin
              starve <= 2'd0;
            end else if (i_req) begin
              starve <= starve + 2'd1;
            end
`endif
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          cnt    <= 4'(LATENCY);
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            if (!is_store) begin
              if (owner) begin
                d_rdata <= mem_rdata;
              end else begin
                i_rdata <= mem_rdata;
              end
            end
            // The pulse is launched here so that it is visible during RESP.
            d_valid <= owner;
            i_valid <= !owner;
            cnt     <= 4'd0;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
